chan_mix: RTL and testbench

Consumer side of the DMA channel record stream. Pops the 6-byte per-channel records (addrhi, addrmid, addrlo, frac, vl, vr) that the channel controller pushes into the FIFO, fetches the two neighbouring 8-bit signed samples from sample memory, linearly interpolates by `frac`, scales by the left and right volumes, and accumulates one 37500 Hz output frame. On each `sync_stb` the accumulated L/R sums are latched to the DAC/output path.

---
 rtl/chan_mix.sv | 192 +++++++++++++++++++
 tb/tb_chan_mix.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_mix.sv
// chan_mix: consumer side of the DMA channel record stream.
// Pops 6-byte channel records (addrhi, addrmid, addrlo, frac, vl, vr) from a
// show-ahead FIFO. For each record it fetches two neighbouring signed samples,
// linearly interpolates between them by frac, scales the result by the left and
// right volumes, and accumulates one output frame. sync_stb latches the frame.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   ena                  global enable, gates FIFO pops only
//   sync_stb             1-cycle frame strobe
//   fifo_data/empty/rd   FIFO head byte, empty flag, combinational pop strobe
//   mem_addr/req         registered sample read address and request
//   mem_ack/data         request accepted, signed sample byte valid this cycle
//   sum_l/sum_r          registered signed frame sums (21 bit)
//   sum_cnt              records accumulated in the latched frame (0..32)
//   sum_stb              1-cycle pulse the cycle after sync_stb
module chan_mix (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        sync_stb,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  output logic [23:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [20:0] sum_l,
  output logic [20:0] sum_r,
  output logic [5:0]  sum_cnt,
  output logic        sum_stb
);

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    FETCH0  = 3'd1,
    FETCH1  = 3'd2,
    INTERP  = 3'd3,
    MUL     = 3'd4,
    ACC     = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [2:0]         idx_q;
  logic [23:0]        addr_q;
  logic [7:0]         frac_q, vl_q, vr_q;
  logic [7:0]         s0_q, s1_q, s_q;
  logic signed [15:0] pl_q, pr_q;
  logic [20:0]        acc_l_q, acc_r_q;
  logic [5:0]         rec_cnt_q;
  logic               mem_req_q, mem_req_d;
  logic [23:0]        mem_addr_q, mem_addr_d;
  logic [20:0]        sum_l_q, sum_r_q;
  logic [5:0]         sum_cnt_q;
  logic               sum_stb_q;

  logic               mem_hit;
  logic signed [17:0] diff, frac_ext, prod, interp;
  logic [7:0]         s_d;
  logic signed [15:0] s_ext, vl_ext, vr_ext, pl_d, pr_d;
  logic [20:0]        term_l, term_r;

  // mem_ack only counts while a request is actually outstanding.
  assign mem_hit = mem_req_q & mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (fifo_rd && idx_q == 3'd5) state_d = FETCH0;
      FETCH0:  if (mem_hit) state_d = FETCH1;
      FETCH1:  if (mem_hit) state_d = INTERP;
      INTERP:  state_d = MUL;
      MUL:     state_d = ACC;
      ACC:     state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Request and address are registered from the next state so they appear in
  // the first FETCH cycle and hold steady until acknowledged.
  always_comb begin
    fifo_rd    = (state_q == COLLECT) & ena & ~fifo_empty;
    mem_req_d  = (state_d == FETCH0) || (state_d == FETCH1);
    mem_addr_d = mem_addr_q;
    if (state_d == FETCH0)      mem_addr_d = addr_q;
    else if (state_d == FETCH1) mem_addr_d = addr_q + 24'd1;
  end

  // Interpolation at 18-bit signed: s0*256 + (s1-s0)*frac, floor-shifted by 8.
  always_comb begin
    diff     = {{10{s1_q[7]}}, s1_q} - {{10{s0_q[7]}}, s0_q};
    frac_ext = {10'd0, frac_q};
    prod     = diff * frac_ext;
    interp   = {{2{s0_q[7]}}, s0_q, 8'd0} + prod;
    s_d      = 8'(interp >>> 8);
    s_ext    = {{8{s_q[7]}}, s_q};
    vl_ext   = {8'd0, vl_q};
    vr_ext   = {8'd0, vr_q};
    pl_d     = s_ext * vl_ext;
    pr_d     = s_ext * vr_ext;
    term_l   = {{5{pl_q[15]}}, pl_q};
    term_r   = {{5{pr_q[15]}}, pr_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= 3'd0;
      addr_q     <= 24'd0;
      frac_q     <= 8'd0;
      vl_q       <= 8'd0;
      vr_q       <= 8'd0;
      s0_q       <= 8'd0;
      s1_q       <= 8'd0;
      s_q        <= 8'd0;
      pl_q       <= 16'sd0;
      pr_q       <= 16'sd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 24'd0;
    end else begin
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if (fifo_rd) begin
        idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        case (idx_q)
          3'd0:    addr_q[23:16] <= fifo_data;
          3'd1:    addr_q[15:8]  <= fifo_data;
          3'd2:    addr_q[7:0]   <= fifo_data;
          3'd3:    frac_q        <= fifo_data;
          3'd4:    vl_q          <= fifo_data;
          3'd5:    vr_q          <= fifo_data;
          default: ;
        endcase
      end
      if (state_q == FETCH0 && mem_hit) s0_q <= mem_data;
      if (state_q == FETCH1 && mem_hit) s1_q <= mem_data;
      if (state_q == INTERP) s_q <= s_d;
      if (state_q == MUL) begin
        pl_q <= pl_d;
        pr_q <= pr_d;
      end
    end
  end

  // A record finishing on the sync edge opens the new frame instead of
  // landing in the frame being latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_l_q   <= 21'd0;
      acc_r_q   <= 21'd0;
      rec_cnt_q <= 6'd0;
      sum_l_q   <= 21'd0;
      sum_r_q   <= 21'd0;
      sum_cnt_q <= 6'd0;
      sum_stb_q <= 1'b0;
    end else begin
      sum_stb_q <= sync_stb;
      if (sync_stb) begin
        sum_l_q   <= acc_l_q;
        sum_r_q   <= acc_r_q;
        sum_cnt_q <= rec_cnt_q;
        if (state_q == ACC) begin
          acc_l_q   <= term_l;
          acc_r_q   <= term_r;
          rec_cnt_q <= 6'd1;
        end else begin
          acc_l_q   <= 21'd0;
          acc_r_q   <= 21'd0;
          rec_cnt_q <= 6'd0;
        end
      end else if (state_q == ACC) begin
        acc_l_q <= acc_l_q + term_l;
        acc_r_q <= acc_r_q + term_r;
        if (rec_cnt_q != 6'd32) rec_cnt_q <= rec_cnt_q + 6'd1;
      end
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign sum_l    = sum_l_q;
  assign sum_r    = sum_r_q;
  assign sum_cnt  = sum_cnt_q;
  assign sum_stb  = sum_stb_q;

endmodule

// File: tb/tb_chan_mix.sv
// tb_chan_mix: directed bench for chan_mix. Record vectors come from a table
// of hand-computed results; multi-cycle corner cases (sync/ACC collision,
// enable hold, mid-record reset, random memory latency) are written out.
module tb_chan_mix;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        sync_stb;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic [20:0] sum_l, sum_r;
  logic [5:0]  sum_cnt;
  logic        sum_stb;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  s0, s1, frac, vl, vr;
    int          expL, expR;
  } vec_t;

  vec_t vecs[8];

  logic [7:0]  fifoQ[$];
  logic [23:0] reqLog[$];
  logic [7:0]  memModel[int unsigned];
  bit          forceEmpty = 1'b1;
  bit          randomLat = 1'b0;
  int          popCnt = 0;

  bit          pending = 1'b0;
  logic [23:0] reqAddr = 24'd0;
  int          waitLeft = 0;

  chan_mix dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sync_stb(sync_stb),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_data(mem_data), .sum_l(sum_l), .sum_r(sum_r),
    .sum_cnt(sum_cnt), .sum_stb(sum_stb)
  );

  always #21 clk = ~clk;

  function automatic logic [7:0] memRead(logic [23:0] a);
    int unsigned k;
    k = int'(a);
    return memModel.exists(k) ? memModel[k] : 8'h00;
  endfunction

  task automatic refreshFifo();
    fifo_empty = forceEmpty || (fifoQ.size() == 0);
    fifo_data  = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
  endtask

  // FIFO model: pop takes effect just after the edge that sampled fifo_rd.
  always @(posedge clk) begin
    automatic bit p = fifo_rd;
    #1;
    if (p && fifoQ.size() > 0) begin
      void'(fifoQ.pop_front());
      popCnt++;
    end
    refreshFifo();
  end

  // Memory responder: 0 or 0..5 cycles of latency per request, and the
  // address must hold while a request waits.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      if (!pending) begin
        pending = 1'b1;
        reqAddr = mem_addr;
        reqLog.push_back(mem_addr);
        waitLeft = randomLat ? int'($urandom_range(5, 0)) : 0;
      end else begin
        checks++;
        if (mem_addr !== reqAddr) begin
          failures++;
          $display("[TB] FAIL addr_stable actual=%h required=%h", mem_addr, reqAddr);
        end
      end
      if (waitLeft == 0) begin
        mem_ack  = 1'b1;
        mem_data = memRead(mem_addr);
        pending  = 1'b0;
      end else begin
        waitLeft--;
      end
    end else begin
      pending = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  task automatic pushRecord(input logic [23:0] a, input logic [7:0] f,
                            input logic [7:0] l, input logic [7:0] r);
    fifoQ.push_back(a[23:16]);
    fifoQ.push_back(a[15:8]);
    fifoQ.push_back(a[7:0]);
    fifoQ.push_back(f);
    fifoQ.push_back(l);
    fifoQ.push_back(r);
    refreshFifo();
  endtask

  task automatic waitIdle(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 6 && n < 3000) begin
      @(negedge clk);
      n++;
      if (fifoQ.size() == 0 && !mem_req) quiet++;
      else quiet = 0;
    end
    if (quiet < 6) timeoutFail(name);
  endtask

  task automatic waitPops(input int target, input string name);
    int n = 0;
    while (popCnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (popCnt < target) timeoutFail(name);
  endtask

  // Pulse sync and verify the latched frame plus a single-cycle sum_stb.
  task automatic checkFrame(input string name, input int expL, input int expR, input int expCnt);
    @(negedge clk);
    sync_stb = 1'b1;
    @(negedge clk);
    sync_stb = 1'b0;
    checkOutput({name, "_stb_hi"}, int'(sum_stb), 1);
    checkOutput({name, "_sum_l"}, $signed(sum_l), expL);
    checkOutput({name, "_sum_r"}, $signed(sum_r), expR);
    checkOutput({name, "_sum_cnt"}, int'(sum_cnt), expCnt);
    @(negedge clk);
    checkOutput({name, "_stb_lo"}, int'(sum_stb), 0);
  endtask

  task automatic checkReqs(input string name, input logic [23:0] a);
    logic [23:0] a1;
    a1 = a + 24'd1;
    checkOutput({name, "_nreq"}, reqLog.size(), 2);
    checkOutput({name, "_req0"}, (reqLog.size() > 0) ? int'(reqLog[0]) : -1, int'(a));
    checkOutput({name, "_req1"}, (reqLog.size() > 1) ? int'(reqLog[1]) : -1, int'(a1));
  endtask

  task automatic applyStimulus(input vec_t v, input int i);
    logic [23:0] a1;
    string nm;
    a1 = v.addr + 24'd1;
    nm = $sformatf("vec%0d", i);
    memModel[int'(v.addr)] = v.s0;
    memModel[int'(a1)] = v.s1;
    reqLog.delete();
    pushRecord(v.addr, v.frac, v.vl, v.vr);
    waitIdle({nm, "_idle"});
    checkReqs(nm, v.addr);
    checkFrame(nm, v.expL, v.expR, 1);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_fifo_rd"}, int'(fifo_rd), 0);
    checkOutput({name, "_mem_req"}, int'(mem_req), 0);
    checkOutput({name, "_mem_addr"}, int'(mem_addr), 0);
    checkOutput({name, "_sum_l"}, $signed(sum_l), 0);
    checkOutput({name, "_sum_r"}, $signed(sum_r), 0);
    checkOutput({name, "_sum_cnt"}, int'(sum_cnt), 0);
    checkOutput({name, "_sum_stb"}, int'(sum_stb), 0);
  endtask

  initial begin
    int base;
    bit rdSeen;

    vecs[0] = '{24'h012345, 8'h10, 8'h00, 8'h00, 8'h40, 8'h80, 1024, 2048};
    vecs[1] = '{24'h000200, 8'h00, 8'h40, 8'h80, 8'h01, 8'h02, 32, 64};
    vecs[2] = '{24'h000300, 8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00, 126, 0};
    vecs[3] = '{24'h000400, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h03, -1, -3};
    vecs[4] = '{24'h000500, 8'h7F, 8'h7F, 8'h33, 8'hFF, 8'hFF, 32385, 32385};
    vecs[5] = '{24'h000600, 8'h40, 8'hC0, 8'h40, 8'h10, 8'h00, 512, 0};
    vecs[6] = '{24'h000700, 8'hF0, 8'h10, 8'h01, 8'h02, 8'h05, -32, -80};
    vecs[7] = '{24'hFFFFFF, 8'h05, 8'h09, 8'h80, 8'h03, 8'h01, 21, 7};

    rst_n = 1'b0;
    ena = 1'b0;
    sync_stb = 1'b0;
    forceEmpty = 1'b1;
    refreshFifo();
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    ena = 1'b1;
    forceEmpty = 1'b0;
    refreshFifo();

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Full frame of 32 worst-case records, zero then random latency.
    memModel[32'h100] = 8'h80;
    memModel[32'h101] = 8'h80;
    for (int i = 0; i < 32; i++) pushRecord(24'h000100, 8'h5A, 8'hFF, 8'hFF);
    waitIdle("full_idle");
    checkFrame("full", -1044480, -1044480, 32);
    randomLat = 1'b1;
    for (int i = 0; i < 32; i++) pushRecord(24'h000100, 8'h11, 8'hFF, 8'hFF);
    waitIdle("fullrand_idle");
    checkFrame("fullrand", -1044480, -1044480, 32);
    randomLat = 1'b0;

    // sync_stb on the ACC edge of the second of two records.
    base = popCnt;
    pushRecord(24'h012345, 8'h00, 8'h01, 8'h01);
    pushRecord(24'h012345, 8'h00, 8'h02, 8'h03);
    waitPops(base + 12, "collide_pops");
    repeat (4) @(negedge clk);
    sync_stb = 1'b1;
    @(negedge clk);
    sync_stb = 1'b0;
    checkOutput("collide_stb", int'(sum_stb), 1);
    checkOutput("collide_sum_l", $signed(sum_l), 16);
    checkOutput("collide_sum_r", $signed(sum_r), 16);
    checkOutput("collide_sum_cnt", int'(sum_cnt), 1);
    waitIdle("collide_idle");
    checkFrame("collide_next", 32, 48, 1);

    // Enable held low mid-record while the FIFO flag toggles.
    base = popCnt;
    pushRecord(24'h012345, 8'h00, 8'h03, 8'h04);
    waitPops(base + 3, "hold_pops");
    ena = 1'b0;
    rdSeen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      forceEmpty = i[0];
      refreshFifo();
      @(negedge clk);
      if (fifo_rd) rdSeen = 1'b1;
    end
    checkOutput("hold_no_rd", int'(rdSeen), 0);
    checkOutput("hold_popcnt", popCnt - base, 3);
    ena = 1'b1;
    forceEmpty = 1'b0;
    refreshFifo();
    waitIdle("hold_idle");
    checkOutput("hold_popcnt_end", popCnt - base, 6);
    checkFrame("hold", 48, 64, 1);

    // Reset after four bytes of a record; the next six form a fresh record.
    base = popCnt;
    fifoQ.push_back(8'hAB);
    fifoQ.push_back(8'hCD);
    fifoQ.push_back(8'hEF);
    fifoQ.push_back(8'h12);
    refreshFifo();
    waitPops(base + 4, "rst_pops");
    forceEmpty = 1'b1;
    refreshFifo();
    rst_n = 1'b0;
    @(negedge clk);
    checkResetOutputs("midrst");
    rst_n = 1'b1;
    forceEmpty = 1'b0;
    reqLog.delete();
    pushRecord(24'h012345, 8'h00, 8'h01, 8'h01);
    waitIdle("rst_idle");
    checkReqs("rst", 24'h012345);
    checkFrame("rst", 16, 16, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
